// File: rtl/sdr_cmd_seq.sv
// Single-request SDRAM command sequencer: power-up init, periodic refresh and
// ACTIVE -> READ/WRITE with auto-precharge for one request at a time.
module sdr_cmd_seq #(
    parameter int SDR_DW       = 16,
    parameter int SDR_BW       = 2,
    parameter int BURST_LENGTH = 1,
    parameter int TRCD         = 3,
    parameter int TRAS         = 6,
    parameter int TRP          = 3,
    parameter int TCAS         = 3,
    parameter int TWR          = 2,
    parameter int TRFC         = 7,
    parameter int INIT_WAIT    = 100,
    parameter int REF_INTERVAL = 780
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_bank,
    input  logic [12:0]       req_row,
    input  logic [9:0]        req_col,
    input  logic [SDR_DW-1:0] wr_data,
    input  logic [SDR_BW-1:0] wr_mask,
    output logic              wr_data_ack,
    output logic [SDR_DW-1:0] rd_data,
    output logic              rd_valid,
    output logic              sdr_init_done,
    output logic              sdr_cke,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [1:0]        sdr_ba,
    output logic [12:0]       sdr_addr,
    output logic [SDR_BW-1:0] sdr_dqm,
    output logic [SDR_DW-1:0] sdr_dout,
    output logic [SDR_BW-1:0] sdr_den_n,
    input  logic [SDR_DW-1:0] sdr_din
);

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam logic [2:0] BL_CODE = (BURST_LENGTH == 8) ? 3'd3 :
                                     (BURST_LENGTH == 4) ? 3'd2 :
                                     (BURST_LENGTH == 2) ? 3'd1 : 3'd0;
    localparam logic [12:0] MRS_ADDR = {3'b000, 1'b0, 2'b00, 3'(TCAS), 1'b0, BL_CODE};

    // Write tail covers both write recovery and the ACTIVE-to-precharge minimum.
    localparam int WR_TAIL_A = TWR + TRP;
    localparam int WR_TAIL_B = TRAS + TRP - (TRCD + BURST_LENGTH);
    localparam int WR_TAIL   = (WR_TAIL_A > WR_TAIL_B) ? WR_TAIL_A : WR_TAIL_B;
    localparam int RD_X1     = TRAS + TRP - TRCD;
    localparam int RD_X2     = BURST_LENGTH + TRP;
    localparam int RD_X3     = TCAS + BURST_LENGTH;
    localparam int RD_X12    = (RD_X1 > RD_X2) ? RD_X1 : RD_X2;
    localparam int RD_X      = (RD_X12 > RD_X3) ? RD_X12 : RD_X3;

    localparam logic [15:0] C_INIT    = 16'(INIT_WAIT - 1);
    localparam logic [15:0] C_TRP     = 16'(TRP);
    localparam logic [15:0] C_TRFC    = 16'(TRFC);
    localparam logic [15:0] C_MRS     = 16'd2;
    localparam logic [15:0] C_ACK     = 16'(TRCD - 2);
    localparam logic [15:0] C_RW      = 16'(TRCD - 1);
    localparam logic [15:0] C_WR_END  = 16'(BURST_LENGTH + WR_TAIL - 1);
    localparam logic [15:0] C_RD_END  = 16'(RD_X - 1);
    localparam logic [15:0] C_SAMP_LO = 16'(TCAS);
    localparam logic [15:0] C_SAMP_HI = 16'(TCAS + BURST_LENGTH);
    localparam logic [15:0] C_REF_END = 16'(REF_INTERVAL - 1);
    localparam logic [3:0]  C_BEAT_END = 4'(BURST_LENGTH - 1);

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
        S_IDLE, S_REF, S_ACT, S_WR, S_RD
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       ref_cnt_q, ref_cnt_d;
    logic              ref_pending_q, ref_pending_d;
    logic              init_done_q, init_done_d;
    logic [3:0]        cmd_q, cmd_d;
    logic              cke_q, cke_d;
    logic [1:0]        ba_q, ba_d;
    logic [12:0]       addr_q, addr_d;
    logic [SDR_BW-1:0] dqm_q, dqm_d;
    logic [SDR_DW-1:0] dout_q, dout_d;
    logic [SDR_BW-1:0] den_n_q, den_n_d;
    logic              we_q, we_d;
    logic [1:0]        bank_q, bank_d;
    logic [9:0]        col_q, col_d;
    logic              wr_ack_q, wr_ack_d;
    logic [3:0]        wbeat_q, wbeat_d;
    logic [SDR_DW-1:0] din_q, din_d;
    logic              samp_q, samp_d;
    logic              rd_valid_q, rd_valid_d;
    logic [SDR_DW-1:0] rd_data_q, rd_data_d;
    logic              ref_expire, ref_clr;

    assign req_ready     = (state_q == S_IDLE) & init_done_q & ~ref_pending_q;
    assign wr_data_ack   = wr_ack_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign sdr_init_done = init_done_q;
    assign sdr_cke       = cke_q;
    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
    assign sdr_ba        = ba_q;
    assign sdr_addr      = addr_q;
    assign sdr_dqm       = dqm_q;
    assign sdr_dout      = dout_q;
    assign sdr_den_n     = den_n_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        init_done_d = init_done_q;
        cmd_d       = CMD_NOP;
        cke_d       = cke_q;
        ba_d        = ba_q;
        addr_d      = addr_q;
        dqm_d       = '1;
        dout_d      = dout_q;
        den_n_d     = '1;
        we_d        = we_q;
        bank_d      = bank_q;
        col_d       = col_q;
        wr_ack_d    = 1'b0;
        wbeat_d     = wbeat_q;
        din_d       = din_q;
        samp_d      = 1'b0;
        rd_valid_d  = samp_q;
        rd_data_d   = samp_q ? din_q : rd_data_q;
        ref_clr     = 1'b0;
        ref_expire  = 1'b0;
        ref_cnt_d   = ref_cnt_q;

        if (init_done_q) begin
            if (ref_cnt_q == C_REF_END) begin
                ref_cnt_d  = '0;
                ref_expire = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 16'd1;
            end
        end

        // Keep DQM low around a read so the SDRAM drives its data.
        if (!we_q && (state_q == S_ACT || state_q == S_RD)) dqm_d = '0;

        // Pin registers take the beat that was acknowledged in the previous cycle.
        if (wr_ack_q) begin
            dout_d  = wr_data;
            dqm_d   = wr_mask;
            den_n_d = '0;
            if (wbeat_q != C_BEAT_END) begin
                wr_ack_d = 1'b1;
                wbeat_d  = wbeat_q + 4'd1;
            end
        end

        case (state_q)
            S_INIT_WAIT: begin
                cke_d = 1'b1;
                if (cnt_q == C_INIT) begin
                    cmd_d   = CMD_PRE;
                    addr_d  = 13'h0400;
                    state_d = S_INIT_PRE;
                    cnt_d   = '0;
                end
            end
            S_INIT_PRE: if (cnt_q == C_TRP) begin
                cmd_d   = CMD_REF;
                state_d = S_INIT_REF1;
                cnt_d   = '0;
            end
            S_INIT_REF1: if (cnt_q == C_TRFC) begin
                cmd_d   = CMD_REF;
                state_d = S_INIT_REF2;
                cnt_d   = '0;
            end
            S_INIT_REF2: if (cnt_q == C_TRFC) begin
                cmd_d   = CMD_MRS;
                ba_d    = 2'b00;
                addr_d  = MRS_ADDR;
                state_d = S_INIT_MRS;
                cnt_d   = '0;
            end
            S_INIT_MRS: if (cnt_q == C_MRS) begin
                init_done_d = 1'b1;
                state_d     = S_IDLE;
                cnt_d       = '0;
            end
            S_IDLE: begin
                cnt_d = '0;
                if (ref_pending_q) begin
                    cmd_d   = CMD_REF;
                    ba_d    = 2'b00;
                    addr_d  = 13'h0400;
                    ref_clr = 1'b1;
                    state_d = S_REF;
                end else if (req_valid && req_ready) begin
                    cmd_d   = CMD_ACT;
                    ba_d    = req_bank;
                    addr_d  = req_row;
                    we_d    = req_we;
                    bank_d  = req_bank;
                    col_d   = req_col;
                    state_d = S_ACT;
                end
            end
            S_REF: if (cnt_q == C_TRFC) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            S_ACT: begin
                if (we_q && cnt_q == C_ACK) begin
                    wr_ack_d = 1'b1;
                    wbeat_d  = 4'd0;
                end
                if (cnt_q == C_RW) begin
                    cmd_d   = we_q ? CMD_WRITE : CMD_READ;
                    ba_d    = bank_q;
                    addr_d  = {2'b00, 1'b1, col_q};
                    state_d = we_q ? S_WR : S_RD;
                    cnt_d   = '0;
                end
            end
            S_WR: if (cnt_q == C_WR_END) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            S_RD: begin
                if (cnt_q >= C_SAMP_LO && cnt_q < C_SAMP_HI) begin
                    samp_d = 1'b1;
                    din_d  = sdr_din;
                end
                if (cnt_q == C_RD_END) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_INIT_WAIT;
        endcase

        ref_pending_d = (ref_pending_q & ~ref_clr) | ref_expire;
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_q       <= S_INIT_WAIT;
            cnt_q         <= '0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            init_done_q   <= 1'b0;
            cmd_q         <= 4'b1111;
            cke_q         <= 1'b0;
            ba_q          <= '0;
            addr_q        <= '0;
            dqm_q         <= '1;
            dout_q        <= '0;
            den_n_q       <= '1;
            we_q          <= 1'b0;
            bank_q        <= '0;
            col_q         <= '0;
            wr_ack_q      <= 1'b0;
            wbeat_q       <= '0;
            din_q         <= '0;
            samp_q        <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            init_done_q   <= init_done_d;
            cmd_q         <= cmd_d;
            cke_q         <= cke_d;
            ba_q          <= ba_d;
            addr_q        <= addr_d;
            dqm_q         <= dqm_d;
            dout_q        <= dout_d;
            den_n_q       <= den_n_d;
            we_q          <= we_d;
            bank_q        <= bank_d;
            col_q         <= col_d;
            wr_ack_q      <= wr_ack_d;
            wbeat_q       <= wbeat_d;
            din_q         <= din_d;
            samp_q        <= samp_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_sdr_cmd_seq.sv
// Directed bench for sdr_cmd_seq: init timing, write/read bursts, refresh under load
// and reset in the middle of a write burst.
module tb_sdr_cmd_seq;

    localparam int DW   = 16;
    localparam int BW   = 2;
    localparam int BL   = 4;
    localparam int RI   = 50;
    localparam int TRFC = 7;
    localparam int TRCD = 3;
    localparam int TRAS_TRP = 9;

    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0, req_we = 1'b0;
    logic          req_ready;
    logic [1:0]    req_bank = '0;
    logic [12:0]   req_row = '0;
    logic [9:0]    req_col = '0;
    logic [DW-1:0] wr_data = '0;
    logic [BW-1:0] wr_mask = '0;
    logic          wr_data_ack, rd_valid, sdr_init_done;
    logic [DW-1:0] rd_data, sdr_dout;
    logic [DW-1:0] sdr_din = '0;
    logic          sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [1:0]    sdr_ba;
    logic [12:0]   sdr_addr;
    logic [BW-1:0] sdr_dqm, sdr_den_n;
    logic [3:0]    cmd;

    int cyc = 0;
    int n_total = 0, n_pass = 0;
    int last_act = -1000, last_ref = -1000, ref_base = 0, n_ref = 0;
    logic prev_done = 1'b0;

    assign cmd = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdr_cmd_seq #(
        .SDR_DW(DW), .SDR_BW(BW), .BURST_LENGTH(BL), .TRCD(TRCD), .TRAS(6), .TRP(3),
        .TCAS(3), .TWR(2), .TRFC(TRFC), .INIT_WAIT(100), .REF_INTERVAL(RI)
    ) dut (
        .sdram_clk(clk), .sdram_resetn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_data_ack(wr_data_ack),
        .rd_data(rd_data), .rd_valid(rd_valid), .sdr_init_done(sdr_init_done),
        .sdr_cke(sdr_cke), .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n),
        .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n), .sdr_ba(sdr_ba),
        .sdr_addr(sdr_addr), .sdr_dqm(sdr_dqm), .sdr_dout(sdr_dout),
        .sdr_den_n(sdr_den_n), .sdr_din(sdr_din)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cke"}, sdr_cke, 0);
        check({tag, "_cmd"}, cmd, 4'hF);
        check({tag, "_ba_addr"}, {sdr_ba, sdr_addr}, 0);
        check({tag, "_dqm_den"}, {sdr_dqm, sdr_den_n}, 4'hF);
        check({tag, "_dout"}, sdr_dout, 0);
        check({tag, "_flags"}, {req_ready, wr_data_ack, rd_valid, sdr_init_done}, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic check_init(input int t0);
        tick_to(t0 + 1);
        check("init_cke", sdr_cke, 1);
        check("init_nop1", cmd, NOP);
        tick_to(t0 + 50);
        check("init_quiet", {wr_data_ack, rd_valid, sdr_init_done}, 0);
        tick_to(t0 + 99);
        check("init_nop99", cmd, NOP);
        tick_to(t0 + 100);
        check("init_pre", cmd, PRE);
        check("init_pre_a10", sdr_addr[10], 1);
        tick_to(t0 + 103);
        check("init_nop103", cmd, NOP);
        tick_to(t0 + 104);
        check("init_ref1", cmd, REF);
        tick_to(t0 + 112);
        check("init_ref2", cmd, REF);
        tick_to(t0 + 120);
        check("init_mrs", cmd, MRS);
        check("init_mrs_addr", sdr_addr, 13'h032);
        tick_to(t0 + 122);
        check("init_done_early", sdr_init_done, 0);
        tick_to(t0 + 123);
        check("init_done", sdr_init_done, 1);
        check("init_ready", req_ready, 1);
    endtask

    task automatic do_accept(input logic we, input logic [1:0] b, input logic [12:0] r,
                             input logic [9:0] c, output int a);
        int w;
        w = 0;
        req_we = we; req_bank = b; req_row = r; req_col = c; req_valid = 1'b1;
        while (!req_ready && w < 200) begin
            tick();
            w++;
        end
        check("accept_wait", (w < 200), 1);
        tick();
        req_valid = 1'b0;
        a = cyc;
    endtask

    // Command-stream monitor: timing legality and refresh cadence.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sdr_init_done && !prev_done) begin
                ref_base = cyc;
                n_ref = 0;
            end
            prev_done = sdr_init_done;
            if (cmd == REF) begin
                if (sdr_init_done) begin
                    check("mon_ref_gap", ((cyc - ref_base) >= RI - 14) && ((cyc - ref_base) <= RI + 14), 1);
                    check("mon_ref_addr", {sdr_ba, sdr_addr[10]}, 3'b001);
                    check("mon_ref_after_act", (cyc - last_act) >= TRAS_TRP, 1);
                    ref_base = cyc;
                    n_ref = n_ref + 1;
                end
                last_ref = cyc;
            end
            if (cmd == ACT) begin
                check("mon_act_after_ref", (cyc - last_ref) > TRFC, 1);
                check("mon_act_after_act", (cyc - last_act) >= TRAS_TRP, 1);
                last_act = cyc;
            end
            if (cmd == RD || cmd == WR)
                check("mon_trcd", cyc - last_act, TRCD);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] wd [4];
        logic [BW-1:0] wm [4];
        int t0, t1, a, beat, pulses, n_acc, exp_ref, base_done;
        logic acc;
        wd[0] = 16'hBEEF; wd[1] = 16'h1234; wd[2] = 16'h5678; wd[3] = 16'h9ABC;
        wm[0] = 2'b00; wm[1] = 2'b01; wm[2] = 2'b10; wm[3] = 2'b00;

        #1 rst_n = 1'b0;
        #11;
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        t0 = cyc;
        check_init(t0);
        base_done = t0 + 123;

        // Write burst: bank 2, row 0x1A5, col 0x040
        do_accept(1'b1, 2'd2, 13'h1A5, 10'h040, a);
        beat = 0;
        for (int k = 0; k <= 12; k++) begin
            case (k)
                0: begin check("wr_act", cmd, ACT); check("wr_act_ba", sdr_ba, 2); check("wr_act_row", sdr_addr, 13'h1A5); end
                1: begin check("wr_nop1", cmd, NOP); check("wr_ack_early", wr_data_ack, 0); end
                2: check("wr_ack0", wr_data_ack, 1);
                3: begin
                    check("wr_cmd", cmd, WR); check("wr_cmd_addr", sdr_addr, 13'h440);
                    check("wr_cmd_ba", sdr_ba, 2); check("wr_den0", sdr_den_n, 0);
                    check("wr_dout0", sdr_dout, 16'hBEEF); check("wr_dqm0", sdr_dqm, 0);
                end
                4: begin check("wr_dout1", sdr_dout, 16'h1234); check("wr_dqm1", sdr_dqm, 1); check("wr_den1", sdr_den_n, 0); end
                5: begin check("wr_dout2", sdr_dout, 16'h5678); check("wr_dqm2", sdr_dqm, 2); check("wr_ack3", wr_data_ack, 1); end
                6: begin check("wr_dout3", sdr_dout, 16'h9ABC); check("wr_dqm3", sdr_dqm, 0); check("wr_ack_end", wr_data_ack, 0); end
                7: check("wr_den_off", sdr_den_n, 2'b11);
                11: check("wr_ready_low", req_ready, 0);
                12: check("wr_ready_high", req_ready, 1);
                default: ;
            endcase
            if (wr_data_ack && beat < 4) begin
                wr_data = wd[beat];
                wr_mask = wm[beat];
                beat++;
            end
            if (k < 12) tick();
        end

        // Read burst: bank 1, row 0x0F0, col 0x3FF, memory returns 1..4
        do_accept(1'b0, 2'd1, 13'h0F0, 10'h3FF, a);
        pulses = 0;
        for (int k = 0; k <= 13; k++) begin
            if (rd_valid) pulses++;
            case (k)
                0: begin check("rd_act", cmd, ACT); check("rd_act_ba", sdr_ba, 1); check("rd_act_row", sdr_addr, 13'h0F0); end
                1: req_valid = 1'b1;
                2: begin req_valid = 1'b0; check("rd_stray_ignored", cmd, NOP); check("rd_no_ack", wr_data_ack, 0); end
                3: begin check("rd_cmd", cmd, RD); check("rd_cmd_addr", sdr_addr, 13'h7FF); check("rd_den_off", sdr_den_n, 2'b11); end
                7: check("rd_valid_early", rd_valid, 0);
                8, 9, 10, 11: begin check("rd_valid", rd_valid, 1); check("rd_data", rd_data, k - 7); end
                9: ;
                12: check("rd_valid_late", rd_valid, 0);
                default: ;
            endcase
            if (k == 9) check("rd_ready_low", req_ready, 0);
            if (k == 10) check("rd_ready_high", req_ready, 1);
            sdr_din = (k >= 6 && k <= 9) ? DW'(k - 5) : 16'hFFFF;
            tick();
        end
        check("rd_pulses", pulses, 4);
        sdr_din = '0;

        // Back-to-back requests with refresh expiring every RI cycles
        n_acc = 0;
        req_valid = 1'b1;
        req_we = 1'b0;
        for (int i = 0; i < 400; i++) begin
            acc = req_ready;
            req_bank = 2'(i);
            req_row = 13'(i * 7);
            req_col = 10'(i * 3);
            if (wr_data_ack) wr_data = 16'(cyc);
            tick();
            if (acc) begin
                n_acc++;
                req_we = ~req_we;
            end
        end
        req_valid = 1'b0;
        exp_ref = (cyc - base_done) / RI;
        check("soak_accepts", (n_acc >= 20), 1);
        check("soak_ref_count", (n_ref >= exp_ref - 1) && (n_ref <= exp_ref), 1);

        // Reset in the middle of a write burst
        do_accept(1'b1, 2'd3, 13'h0AA, 10'h155, a);
        for (int k = 0; k < 4; k++) begin
            if (wr_data_ack) wr_data = 16'hA5A5;
            tick();
        end
        check("mid_burst_den", sdr_den_n, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midrst_hold", {wr_data_ack, rd_valid, cmd}, 6'h0F);
        end
        rst_n = 1'b1;
        t1 = cyc;
        check_init(t1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sdr_cmd_seq.md
Name: sdr_cmd_seq

Overview:
Single-request SDRAM command sequencer that sits directly upstream of the SDRAM pin interface (sdr_bus ctrlcore side).
- Runs the power-up init sequence, then raises sdr_init_done.
- Issues periodic AUTO_REFRESH.
- Turns one read or write request at a time into ACTIVE -> READ/WRITE-with-auto-precharge, meeting TRCD/TRAS/TRP/TRFC/TWR/TCAS.
- All pin outputs are registered.

Parameters:
SDR_DW, 16, SDRAM data width
SDR_BW, 2, byte-mask width
BURST_LENGTH, 1, beats per access (1/2/4/8)
TRCD, 3, ACTIVE to READ/WRITE, cycles
TRAS, 6, ACTIVE to precharge start minimum, cycles
TRP, 3, precharge period, cycles
TCAS, 3, CAS latency (2 or 3)
TWR, 2, last write beat to precharge, cycles
TRFC, 7, AUTO_REFRESH period, cycles
INIT_WAIT, 100, power-up NOP cycles
REF_INTERVAL, 780, cycles between refresh requests

Ports:
sdram_clk  in  1  clock
sdram_resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=write, 0=read
req_bank  in  2  bank
req_row  in  13  row address
req_col  in  10  column address
wr_data  in  SDR_DW  write beat
wr_mask  in  SDR_BW  write byte mask (1=masked)
wr_data_ack  out  1  current wr_data beat consumed this cycle
rd_data  out  SDR_DW  read beat
rd_valid  out  1  rd_data valid (one pulse per beat)
sdr_init_done  out  1  init sequence complete
sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  out  1 each  SDRAM command pins
sdr_ba  out  2  bank
sdr_addr  out  13  address
sdr_dqm  out  SDR_BW  data mask
sdr_dout  out  SDR_DW  write data
sdr_den_n  out  SDR_BW  output enable, active low
sdr_din  in  SDR_DW  read data

Behaviour:
- Reset (async):
  - cke=0; cs_n/ras_n/cas_n/we_n=1.
  - ba=0, addr=0, dqm=all 1, den_n=all 1, dout=0.
  - req_ready=0, wr_data_ack=0, rd_valid=0, rd_data=0, sdr_init_done=0.
  - All counters = 0; state = INIT_WAIT.
  - Reset mid-operation aborts immediately and init restarts.
- Commands use {cs_n,ras_n,cas_n,we_n}: NOP=0111, ACTIVE=0011, READ=0101, WRITE=0100, PRECHARGE=0010, AUTO_REFRESH=0001, LOAD_MODE=0000. NOP is driven in every cycle not listed below.
- Init states, in order:
  - INIT_WAIT: cke=1, NOP for INIT_WAIT cycles.
  - INIT_PRE: PRECHARGE with addr[10]=1, then TRP cycles.
  - INIT_REF1, INIT_REF2: each AUTO_REFRESH, then TRFC cycles.
  - INIT_MRS: LOAD_MODE with addr = {3'b0, 1'b0, 2'b00, TCAS[2:0], 1'b0, BL code}; BL code 0/1/2/3 for 1/2/4/8. Then 2 NOP cycles.
  - sdr_init_done goes 1 and stays 1 until reset; state -> IDLE.
- Refresh:
  - Counter runs from init_done and sets ref_pending every REF_INTERVAL cycles.
  - In IDLE, ref_pending takes priority over req_valid: issue AUTO_REFRESH (addr[10]=1, ba=0), clear ref_pending, wait TRFC cycles, return to IDLE.
  - A second interval expiring while ref_pending is already set does not queue an extra refresh.
- req_ready = IDLE & init_done & ~ref_pending, combinational from registered state.
- On accept, latch we/bank/row/col and issue ACTIVE in the next cycle (cycle A): ba=bank, addr=row.
- At A+TRCD, issue READ or WRITE: addr = {2'b0, 1'b1, col}, i.e. addr[10]=1 for auto-precharge.
- Write path:
  - Beats driven at A+TRCD .. A+TRCD+BL-1 with den_n=0 and dqm=wr_mask per beat.
  - wr_data_ack is high the cycle before each drive cycle, when wr_data/wr_mask are sampled into the pin registers.
  - After the last beat, wait max(TWR+TRP, TRAS+TRP-(TRCD+BL)) cycles, then IDLE.
- Read path:
  - sdr_din is sampled at edges A+TRCD+TCAS+1 .. +BL; rd_valid/rd_data are registered one cycle after each sample.
  - IDLE is not re-entered before A+TRAS+TRP.
- Column address increments are done by the SDRAM; the sequencer does not wrap the column itself.
- req_valid while not ready: ignored, no side effect.

Test Plan:
- Reset release with defaults -> cke=1 at cycle 1; PRECHARGE at cycle 100; AUTO_REFRESH at 104 and 112; LOAD_MODE at 120 with addr=0x030; sdr_init_done=1 at cycle 123.
- Single write, bank 2, row 0x1A5, col 0x040, data 0xBEEF, mask 0 -> ACTIVE ba=2 addr=0x1A5; WRITE 3 cycles later with addr=0x440, dout=0xBEEF, den_n=00; req_ready low until TRAS+TRP satisfied.
- Read, BL=4, TCAS=3, with the model returning 0x0001..0x0004 -> exactly 4 rd_valid pulses in order, first one 8 cycles after ACTIVE.
- REF_INTERVAL=50 with back-to-back requests -> AUTO_REFRESH issued only from IDLE; no ACTIVE within TRFC after it; refresh never skipped.
- Reset asserted mid-write burst -> all outputs return to reset values immediately; full init sequence repeats; no rd_valid/wr_data_ack glitch.
- Connected to the sdr_bus protocol checker through a 500-request random run -> zero command-legality or TRAS/TRCD/TRP violation messages.
